// File: rtl/oric_bus_pkg.sv
// Shared types for the Oric CPU bus multiplexer: read-source codes, host
// override FSM states and the default bank-register I/O address.
package oric_bus_pkg;

    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_EXP  = 3'd1,
        SRC_VIA  = 3'd2,
        SRC_ROM  = 3'd3,
        SRC_SRAM = 3'd4
    } bus_src_e;

    typedef enum logic [1:0] {
        HOST_IDLE = 2'd0,
        HOST_WAIT = 2'd1,
        HOST_HELD = 2'd2
    } host_st_e;

    localparam logic [15:0] DEF_BANK_ADDR = 16'h03F8;

endpackage

// File: rtl/oric_bank_ctrl.sv
// ROM bank register with delayed CPU switch and host override FSM.
// host_state is exported so the override phase is observable from outside.
module oric_bank_ctrl
    import oric_bus_pkg::*;
#(
    parameter int RB         = 2,
    parameter int SWITCH_DLY = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          phi2_en,
    input  logic          bank_wr,
    input  logic [RB-1:0] wr_bank,
    input  logic          host_req,
    input  logic [RB-1:0] host_bank,
    input  logic [RB-1:0] rom_default,
    output logic [RB-1:0] rom_bank,
    output logic          switch_pend,
    output host_st_e      host_state
);

    logic [RB-1:0] pend_bank;
    logic [3:0]    dly_cnt;
    logic          enter_held;

    assign enter_held = (host_state == HOST_WAIT) && host_req && phi2_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_state  <= HOST_IDLE;
            rom_bank    <= rom_default;
            pend_bank   <= rom_default;
            dly_cnt     <= 4'd0;
            switch_pend <= 1'b0;
        end else begin
            case (host_state)
                HOST_IDLE: if (host_req) host_state <= HOST_WAIT;
                HOST_WAIT: begin
                    if (!host_req)
                        host_state <= HOST_IDLE;
                    else if (phi2_en)
                        host_state <= HOST_HELD;
                end
                HOST_HELD: if (!host_req) host_state <= HOST_IDLE;
                default:   host_state <= HOST_IDLE;
            endcase

            // Host ownership beats any CPU activity, including a same-edge write.
            if (host_state == HOST_HELD) begin
                rom_bank <= host_req ? host_bank : rom_default;
            end else if (enter_held) begin
                rom_bank    <= host_bank;
                switch_pend <= 1'b0;
                dly_cnt     <= 4'd0;
            end else if (bank_wr) begin
                pend_bank   <= wr_bank;
                dly_cnt     <= 4'(SWITCH_DLY);
                switch_pend <= 1'b1;
            end else if (phi2_en && switch_pend) begin
                if (dly_cnt <= 4'd1) begin
                    rom_bank    <= pend_bank;
                    switch_pend <= 1'b0;
                    dly_cnt     <= 4'd0;
                end else begin
                    dly_cnt <= dly_cnt - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/oric_cpu_bus_mux.sv
// Registered CPU read-data mux and ROM bank controller for the Oric bus.
// Build option ORIC_BUS_OPENBUS_EN: unsourced reads hold CPU_DI instead of 8'hFF.
module oric_cpu_bus_mux
    import oric_bus_pkg::*;
#(
    parameter int          NUM_ROMS   = 4,
    parameter int          NUM_EXP    = 2,
    parameter logic [15:0] BANK_ADDR  = DEF_BANK_ADDR,
    parameter int          SWITCH_DLY = 3,
    localparam int         RB         = $clog2(NUM_ROMS)
) (
    input  logic                  CLK_IN,
    input  logic                  RESETn,
    input  logic                  PHI2,
    input  logic                  PHI2_EN,
    input  logic                  CPU_RW,
    input  logic [15:0]           CPU_AD,
    input  logic [7:0]            CPU_DO,
    input  logic                  CSIOn,
    input  logic                  CSROMn,
    input  logic                  CSRAMn,
    input  logic                  LATCH_SRAM,
    input  logic                  MAPn,
    input  logic                  ROMDISn,
    input  logic                  IOCTRLn,
    input  logic [RB-1:0]         ROM_DEFAULT,
    input  logic [7:0]            VIA_DO,
    input  logic [NUM_EXP*8-1:0]  EXP_DO,
    input  logic [NUM_EXP-1:0]    EXP_SELn,
    input  logic [NUM_ROMS*8-1:0] ROM_DO,
    input  logic [7:0]            SRAM_DO,
    input  logic                  HOST_REQ,
    input  logic [RB-1:0]         HOST_BANK,
    output logic                  HOST_ACK,
    output logic [7:0]            CPU_DI,
    output logic [RB-1:0]         ROM_BANK,
    output logic                  SWITCH_PEND,
    output logic [2:0]            BUS_SRC
);

    localparam logic [8:0] ROM_LIMIT = 9'(NUM_ROMS);

    logic     rd;
    logic     bank_sel;
    logic     bank_wr;
    logic     exp_hit;
    logic [7:0] exp_data;
    logic [7:0] mux_do;
    bus_src_e mux_src;
    host_st_e host_state;

    assign rd       = CPU_RW & PHI2;
    assign bank_sel = !CSIOn && (CPU_AD == BANK_ADDR);
    // Out-of-range bank values are dropped here so they never disturb a pending switch.
    assign bank_wr  = !CPU_RW && PHI2 && PHI2_EN && bank_sel && ({1'b0, CPU_DO} < ROM_LIMIT);

    oric_bank_ctrl #(
        .RB         (RB),
        .SWITCH_DLY (SWITCH_DLY)
    ) u_bank_ctrl (
        .clk         (CLK_IN),
        .rst_n       (RESETn),
        .phi2_en     (PHI2_EN),
        .bank_wr     (bank_wr),
        .wr_bank     (CPU_DO[RB-1:0]),
        .host_req    (HOST_REQ),
        .host_bank   (HOST_BANK),
        .rom_default (ROM_DEFAULT),
        .rom_bank    (ROM_BANK),
        .switch_pend (SWITCH_PEND),
        .host_state  (host_state)
    );

    assign HOST_ACK = (host_state == HOST_HELD);

    // Walk from the top so the lowest-numbered selected source is left standing.
    always_comb begin
        exp_hit  = 1'b0;
        exp_data = 8'h00;
        for (int i = NUM_EXP - 1; i >= 0; i--) begin
            if (!EXP_SELn[i]) begin
                exp_hit  = 1'b1;
                exp_data = EXP_DO[8*i +: 8];
            end
        end
    end

    always_comb begin
        mux_src = SRC_NONE;
        mux_do  = 8'hFF;
        if (!CSIOn) begin
            if (!IOCTRLn && exp_hit) begin
                mux_src = SRC_EXP;
                mux_do  = exp_data;
            end else if (bank_sel) begin
                mux_src = SRC_VIA;
                mux_do  = 8'({SWITCH_PEND, ROM_BANK});
            end else if (IOCTRLn) begin
                mux_src = SRC_VIA;
                mux_do  = VIA_DO;
            end
        end else if (!CSROMn && MAPn && ROMDISn) begin
            mux_src = SRC_ROM;
            mux_do  = ROM_DO[8*int'(ROM_BANK) +: 8];
        end else if (!CSRAMn && !LATCH_SRAM) begin
            mux_src = SRC_SRAM;
            mux_do  = SRAM_DO;
        end
    end

    always_ff @(posedge CLK_IN or negedge RESETn) begin
        if (!RESETn) begin
            CPU_DI  <= 8'hFF;
            BUS_SRC <= SRC_NONE;
        end else if (rd) begin
            BUS_SRC <= mux_src;
            if (mux_src != SRC_NONE)
                CPU_DI <= mux_do;
            else
`ifdef ORIC_BUS_OPENBUS_EN
                CPU_DI <= CPU_DI;
`else
                CPU_DI <= 8'hFF;
`endif
        end
    end

endmodule

// File: tb/tb_oric_cpu_bus_mux.sv
// Directed bench for oric_cpu_bus_mux: read expectations go through a scoreboard
// queue checked by a monitor; bank/host status is checked inline.
module tb_oric_cpu_bus_mux;
    import oric_bus_pkg::*;

    localparam int NUM_ROMS = 4;
    localparam int NUM_EXP  = 2;
    localparam int RB       = 2;

    logic                  CLK_IN = 1'b0;
    logic                  RESETn;
    logic                  PHI2, PHI2_EN, CPU_RW;
    logic [15:0]           CPU_AD;
    logic [7:0]            CPU_DO;
    logic                  CSIOn, CSROMn, CSRAMn, LATCH_SRAM, MAPn, ROMDISn, IOCTRLn;
    logic [RB-1:0]         ROM_DEFAULT;
    logic [7:0]            VIA_DO;
    logic [NUM_EXP*8-1:0]  EXP_DO;
    logic [NUM_EXP-1:0]    EXP_SELn;
    logic [NUM_ROMS*8-1:0] ROM_DO;
    logic [7:0]            SRAM_DO;
    logic                  HOST_REQ;
    logic [RB-1:0]         HOST_BANK;
    logic                  HOST_ACK;
    logic [7:0]            CPU_DI;
    logic [RB-1:0]         ROM_BANK;
    logic                  SWITCH_PEND;
    logic [2:0]            BUS_SRC;

    int n_vec = 0;
    int n_err = 0;
    logic [10:0] exp_q[$];
    logic        rd_q = 1'b0;

    oric_cpu_bus_mux #(
        .NUM_ROMS   (NUM_ROMS),
        .NUM_EXP    (NUM_EXP),
        .BANK_ADDR  (16'h03F8),
        .SWITCH_DLY (3)
    ) dut (
        .CLK_IN      (CLK_IN),
        .RESETn      (RESETn),
        .PHI2        (PHI2),
        .PHI2_EN     (PHI2_EN),
        .CPU_RW      (CPU_RW),
        .CPU_AD      (CPU_AD),
        .CPU_DO      (CPU_DO),
        .CSIOn       (CSIOn),
        .CSROMn      (CSROMn),
        .CSRAMn      (CSRAMn),
        .LATCH_SRAM  (LATCH_SRAM),
        .MAPn        (MAPn),
        .ROMDISn     (ROMDISn),
        .IOCTRLn     (IOCTRLn),
        .ROM_DEFAULT (ROM_DEFAULT),
        .VIA_DO      (VIA_DO),
        .EXP_DO      (EXP_DO),
        .EXP_SELn    (EXP_SELn),
        .ROM_DO      (ROM_DO),
        .SRAM_DO     (SRAM_DO),
        .HOST_REQ    (HOST_REQ),
        .HOST_BANK   (HOST_BANK),
        .HOST_ACK    (HOST_ACK),
        .CPU_DI      (CPU_DI),
        .ROM_BANK    (ROM_BANK),
        .SWITCH_PEND (SWITCH_PEND),
        .BUS_SRC     (BUS_SRC)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK_IN = ~CLK_IN;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- monitor / scoreboard ----------------
    always @(posedge CLK_IN) rd_q <= CPU_RW & PHI2;

    always @(negedge CLK_IN) begin
        if (rd_q) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL read_unexpected: actual CPU_DI=%h BUS_SRC=%0d, required no read", CPU_DI, BUS_SRC);
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                n_vec++;
                if (CPU_DI !== e[10:3]) begin
                    n_err++;
                    $display("FAIL read_data: actual=%h required=%h", CPU_DI, e[10:3]);
                end
                n_vec++;
                if (BUS_SRC !== e[2:0]) begin
                    n_err++;
                    $display("FAIL read_src: actual=%0d required=%0d", BUS_SRC, e[2:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK_IN);
        #1;
    endtask

    task automatic bus_idle();
        PHI2 = 1'b0; PHI2_EN = 1'b0; CPU_RW = 1'b1;
        CSIOn = 1'b1; CSROMn = 1'b1; CSRAMn = 1'b1; LATCH_SRAM = 1'b1;
        MAPn = 1'b1; ROMDISn = 1'b1; IOCTRLn = 1'b1; EXP_SELn = '1;
        CPU_AD = 16'h0000; CPU_DO = 8'h00;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_bank(input string name, input logic [7:0] bank, input logic pend, input logic ack);
        check({name, "_bank"}, 8'(ROM_BANK), bank);
        check({name, "_pend"}, 8'(SWITCH_PEND), 8'(pend));
        check({name, "_ack"}, 8'(HOST_ACK), 8'(ack));
    endtask

    // Caller sets the decode strobes; this issues one read cycle and queues the result.
    task automatic do_read(input logic [15:0] addr, input logic [7:0] di, input logic [2:0] src);
        CPU_AD = addr; CPU_RW = 1'b1; PHI2 = 1'b1;
        exp_q.push_back({di, src});
        tick();
        bus_idle();
    endtask

    task automatic strobe();
        PHI2_EN = 1'b1;
        tick();
        PHI2_EN = 1'b0;
    endtask

    task automatic bank_write(input logic [7:0] v);
        CPU_RW = 1'b0; PHI2 = 1'b1; PHI2_EN = 1'b1; CSIOn = 1'b0;
        CPU_AD = 16'h03F8; CPU_DO = v;
        tick();
        bus_idle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus_idle();
        RESETn = 1'b0;
        ROM_DEFAULT = 2'd1;
        ROM_DO = {8'hD4, 8'hC3, 8'hA9, 8'h80};
        EXP_DO = {8'h22, 8'h11};
        VIA_DO = 8'h5A;
        SRAM_DO = 8'h3C;
        HOST_REQ = 1'b0;
        HOST_BANK = 2'd0;
        repeat (3) tick();
        check("rst_cpu_di", CPU_DI, 8'hFF);
        check("rst_bus_src", 8'(BUS_SRC), 8'd0);
        check_bank("rst", 8'd1, 1'b0, 1'b0);
        @(negedge CLK_IN);
        RESETn = 1'b1;
        tick();

        // ROM read from default bank 1
        CSROMn = 1'b0;
        do_read(16'hC000, 8'hA9, 3'd3);

        // delayed switch to bank 2, status readback during countdown
        bank_write(8'h02);
        check_bank("wr2", 8'd1, 1'b1, 1'b0);
        CSIOn = 1'b0;
        do_read(16'h03F8, 8'h05, 3'd2);
        strobe(); check_bank("wr2_s1", 8'd1, 1'b1, 1'b0);
        strobe(); check_bank("wr2_s2", 8'd1, 1'b1, 1'b0);
        strobe(); check_bank("wr2_s3", 8'd2, 1'b0, 1'b0);
        CSROMn = 1'b0;
        do_read(16'hC000, 8'hC3, 3'd3);

        // back to bank 1, then last-write-wins reload
        bank_write(8'h01);
        repeat (3) strobe();
        check_bank("wr1_done", 8'd1, 1'b0, 1'b0);
        bank_write(8'h02);
        strobe(); check_bank("reload_s1", 8'd1, 1'b1, 1'b0);
        bank_write(8'h03);
        strobe(); check_bank("reload_s2", 8'd1, 1'b1, 1'b0);
        strobe(); check_bank("reload_s3", 8'd1, 1'b1, 1'b0);
        strobe(); check_bank("reload_s4", 8'd3, 1'b0, 1'b0);
        bank_write(8'h07);
        check_bank("wr7", 8'd3, 1'b0, 1'b0);
        repeat (3) strobe();
        check_bank("wr7_after", 8'd3, 1'b0, 1'b0);

        // host override cancels a pending switch
        bank_write(8'h02);
        strobe();
        HOST_REQ = 1'b1; HOST_BANK = 2'd0;
        tick(); check_bank("host_wait", 8'd3, 1'b1, 1'b0);
        strobe(); check_bank("host_held", 8'd0, 1'b0, 1'b1);
        bank_write(8'h01);
        check_bank("host_cpu_wr", 8'd0, 1'b0, 1'b1);
        HOST_BANK = 2'd2;
        tick(); check_bank("host_track", 8'd2, 1'b0, 1'b1);
        HOST_REQ = 1'b0;
        tick(); check_bank("host_drop", 8'd1, 1'b0, 1'b0);
        repeat (4) strobe();
        check_bank("host_after", 8'd1, 1'b0, 1'b0);

        // expansion priority and no-source reads
        CSIOn = 1'b0; IOCTRLn = 1'b0; EXP_SELn = 2'b00;
        do_read(16'h0310, 8'h11, 3'd1);
        CSIOn = 1'b0; IOCTRLn = 1'b0; EXP_SELn = 2'b01;
        do_read(16'h0310, 8'h22, 3'd1);
        CSIOn = 1'b0; IOCTRLn = 1'b0; EXP_SELn = 2'b11;
`ifdef ORIC_BUS_OPENBUS_EN
        do_read(16'h0310, 8'h22, 3'd0);
`else
        do_read(16'h0310, 8'hFF, 3'd0);
`endif
        CSIOn = 1'b0; IOCTRLn = 1'b1;
        do_read(16'h0300, 8'h5A, 3'd2);
        CSROMn = 1'b0; CSRAMn = 1'b0; LATCH_SRAM = 1'b0;
        do_read(16'hC000, 8'hA9, 3'd3);
        CSROMn = 1'b0; MAPn = 1'b0; CSRAMn = 1'b0; LATCH_SRAM = 1'b0;
        do_read(16'hC000, 8'h3C, 3'd4);

        // async reset in the middle of a countdown
        bank_write(8'h03);
        repeat (3) strobe();
        bank_write(8'h00);
        strobe();
        check_bank("pre_rst", 8'd3, 1'b1, 1'b0);
        #3 RESETn = 1'b0;
        #1;
        check("arst_cpu_di", CPU_DI, 8'hFF);
        check("arst_bus_src", 8'(BUS_SRC), 8'd0);
        check_bank("arst", 8'd1, 1'b0, 1'b0);
        @(negedge CLK_IN);
        RESETn = 1'b1;
        repeat (4) strobe();
        check_bank("arst_after", 8'd1, 1'b0, 1'b0);

        repeat (3) tick();
        check("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
